issue_select: RTL and testbench
===============================

Name: issue_select

Overview:
- Scheduler for a bank of issue slots.
- Each cycle it picks ready uops from the slots' requests and returns same-cycle grants to them. Granted uops go into a one-entry issue register per port.
- Port 0 is a pipelined single-cycle ALU. Port 1 is an unpipelined divider, sequenced by an internal FSM.
- Drives the two wakeup ports that the slots consume to clear operand busy bits.

Parameters:
NUM_SLOTS, 8, number of issue slots; slot 0 is the oldest
DIV_LAT, 8, divider latency in cycles from grant to wakeup; legal range 2..31
PDST_W, 7, physical destination register width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
io_kill  in  1  pipeline flush
io_slot_request  in  NUM_SLOTS  slot has a ready uop
io_slot_is_div  in  NUM_SLOTS  the requesting uop needs the divider
io_slot_pdst  in  NUM_SLOTS*PDST_W  pdst of each slot, packed with slot i at bits [i*PDST_W +: PDST_W]
io_slot_grant  out  NUM_SLOTS  one-hot per port, combinational, same cycle as the request
io_port0_valid  out  1  ALU issue register valid
io_port0_idx  out  clog2(NUM_SLOTS)  slot index issued on port 0
io_port1_valid  out  1  divider issue register valid
io_port1_idx  out  clog2(NUM_SLOTS)  slot index issued on port 1
io_div_busy  out  1  divider FSM is in BUSY
io_wakeup_ports_0_valid  out  1  ALU result wakeup
io_wakeup_ports_0_bits_pdst  out  PDST_W  pdst for the ALU wakeup
io_wakeup_ports_1_valid  out  1  divider result wakeup
io_wakeup_ports_1_bits_pdst  out  PDST_W  pdst for the divider wakeup

Behaviour:
- Reset: every registered output is 0; divider FSM is IDLE; counter is 0; stored pdst is 0.
- Port 0 select:
  - Candidates are slots with request=1 and is_div=0.
  - Lowest index wins (age order). The winner's grant bit is asserted in the same cycle.
- Port 1 select:
  - Candidates are slots with request=1 and is_div=1.
  - Lowest index wins, only while the FSM is IDLE or DONE.
- A slot is never granted on both ports. At most two grant bits are high in any cycle.
- io_kill=1 forces all grants to 0 combinationally that cycle. The next cycle has port0/port1 valid=0 and wakeup_0 valid=0. The divider FSM goes to IDLE with no wakeup_1, i.e. the in-flight divide is aborted.
- Issue registers: a grant in cycle t gives port valid=1 and idx=winner in cycle t+1. With no grant, valid=0 in t+1.
- Wakeup 0: valid with pdst equal to the granted slot's pdst, captured at grant. It appears in t+1, together with port0_valid.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE or DONE with a div grant: counter<=DIV_LAT-1, pdst latched, next state BUSY.
  - IDLE or DONE without a grant: next state IDLE.
  - BUSY with counter==1: next state DONE. Otherwise counter decrements.
  - DONE drives io_wakeup_ports_1_valid=1 with the latched pdst for exactly one cycle.
  - Net effect: a div granted in cycle t wakes up in cycle t+DIV_LAT.
  - Back-to-back: a new div may be granted in the DONE cycle, so grants can be spaced DIV_LAT cycles apart.
- io_div_busy=1 only in BUSY. Div requests that arrive during BUSY get no grant and are not queued; the slot keeps requesting.
- Counter width is clog2(DIV_LAT+1). It never wraps.
- Reset asserted mid-divide: immediate return to IDLE, all outputs 0.

Optional Feature:
ISSUE_SELECT_RR_EN
- Defined: port 0 uses round-robin. A pointer register (reset 0) marks the highest-priority index. After a port 0 grant to slot k, the pointer becomes (k+1) mod NUM_SLOTS. With no grant the pointer holds. io_kill does not move the pointer.
- Undefined: fixed age priority as described above, and no pointer register exists.
- Port 1 uses age priority in both builds.

Decomposition:
- Package issue_pkg holds:
  - PDST_W default constant
  - div_state_e enum (IDLE=2'b00, BUSY=2'b01, DONE=2'b10)
  - a function giving the slot index width
- One sub-module, issue_pick: find-first-set over NUM_SLOTS with an optional rotate-base input. It outputs found, one-hot and index. Two instances, one per port.

Test Plan:
- Reset, then request=8'b0110_0100 with is_div=0 and slot 2 pdst=7'h15 -> grant=8'b0000_0100 in the same cycle; next cycle port0_valid=1, idx=2, wakeup_0 valid with pdst 7'h15.
- DIV_LAT=4, slot 5 div request in cycle 10 with pdst 7'h33 -> grant bit 5 in cycle 10; io_div_busy=1 in cycles 11-13; wakeup_1 valid with pdst 7'h33 only in cycle 14.
- Div requests on slots 1 and 3, held continuously -> slot 1 granted in cycle t, slot 3 granted in cycle t+DIV_LAT (the DONE cycle), with no grant in between.
- io_kill in cycle 12 during a divide, with an ALU request pending -> zero grants in cycle 12; in cycle 13 both port valids 0 and FSM IDLE; no wakeup_1 ever appears.
- Mixed request=8'b0000_0011 with is_div=8'b0000_0001 -> both ports grant in the same cycle (slot 0 on port 1, slot 1 on port 0), grant=8'b0000_0011.
- ISSUE_SELECT_RR_EN with all 8 slots requesting non-div every cycle -> port 0 grants slots 0,1,2,...,7,0 on consecutive cycles.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the issue_select scheduler.
package issue_pkg;

  localparam int PDST_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/issue_pick.sv
// Find-first-set over N request bits, starting the search at a rotate base.
module issue_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic          found_o,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  localparam int PW = IW + 1;

  logic [PW-1:0] pos_s;

  always_comb begin
    found_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    pos_s    = '0;
    for (int off = 0; off < N; off++) begin
      pos_s = {1'b0, base_i} + PW'(off);
      if (pos_s >= PW'(N)) begin
        pos_s = pos_s - PW'(N);
      end else begin
        pos_s = pos_s;
      end
      if (!found_o && req_i[pos_s[IW-1:0]]) begin
        found_o                  = 1'b1;
        onehot_o[pos_s[IW-1:0]]  = 1'b1;
        idx_o                    = pos_s[IW-1:0];
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Two-port issue scheduler: pipelined ALU on port 0, unpipelined divider on port 1.
// Optional ISSUE_SELECT_RR_EN switches port 0 from age priority to round-robin.
module issue_select
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int DIV_LAT   = 8,
  parameter int PDST_W    = PDST_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_kill,
  input  logic [NUM_SLOTS-1:0]        io_slot_request,
  input  logic [NUM_SLOTS-1:0]        io_slot_is_div,
  input  logic [NUM_SLOTS*PDST_W-1:0] io_slot_pdst,
  output logic [NUM_SLOTS-1:0]        io_slot_grant,
  output logic                        io_port0_valid,
  output logic [slot_idx_w(NUM_SLOTS)-1:0] io_port0_idx,
  output logic                        io_port1_valid,
  output logic [slot_idx_w(NUM_SLOTS)-1:0] io_port1_idx,
  output logic                        io_div_busy,
  output logic                        io_wakeup_ports_0_valid,
  output logic [PDST_W-1:0]           io_wakeup_ports_0_bits_pdst,
  output logic                        io_wakeup_ports_1_valid,
  output logic [PDST_W-1:0]           io_wakeup_ports_1_bits_pdst
);

  localparam int IW = slot_idx_w(NUM_SLOTS);
  localparam int CW = $clog2(DIV_LAT + 1);

  logic [NUM_SLOTS-1:0] alu_req_s, div_req_s, alu_oh_s, div_oh_s;
  logic                 alu_found_s, div_found_s, alu_gnt_s, div_gnt_s;
  logic [IW-1:0]        alu_idx_s, div_idx_s, base_s;

  logic                 p0_valid_q, p1_valid_q;
  logic [IW-1:0]        p0_idx_q, p1_idx_q;
  logic [PDST_W-1:0]    wk0_pdst_q, div_pdst_q;
  div_state_e           state_q;
  logic [CW-1:0]        cnt_q;

  // Divider requests are only eligible when the FSM can accept a new op.
  always_comb begin
    alu_req_s = io_slot_request & ~io_slot_is_div;
    if (state_q != BUSY) begin
      div_req_s = io_slot_request & io_slot_is_div;
    end else begin
      div_req_s = '0;
    end
  end

`ifdef ISSUE_SELECT_RR_EN
  logic [IW-1:0] rr_q;

  // Round-robin pointer: one past the last port 0 winner; holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
    end else if (alu_gnt_s) begin
      rr_q <= (alu_idx_s == IW'(NUM_SLOTS - 1)) ? '0 : alu_idx_s + IW'(1);
    end
  end

  assign base_s = rr_q;
`else
  assign base_s = '0;
`endif

  issue_pick #(.N(NUM_SLOTS), .IW(IW)) u_pick_alu (
    .req_i(alu_req_s), .base_i(base_s),
    .found_o(alu_found_s), .onehot_o(alu_oh_s), .idx_o(alu_idx_s)
  );

  issue_pick #(.N(NUM_SLOTS), .IW(IW)) u_pick_div (
    .req_i(div_req_s), .base_i('0),
    .found_o(div_found_s), .onehot_o(div_oh_s), .idx_o(div_idx_s)
  );

  assign alu_gnt_s     = alu_found_s & ~io_kill;
  assign div_gnt_s     = div_found_s & ~io_kill;
  assign io_slot_grant = io_kill ? '0 : (alu_oh_s | div_oh_s);

  // Issue registers, ALU wakeup capture, and the divider sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_valid_q <= 1'b0;
      p0_idx_q   <= '0;
      p1_valid_q <= 1'b0;
      p1_idx_q   <= '0;
      wk0_pdst_q <= '0;
      div_pdst_q <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
    end else begin
      p0_valid_q <= alu_gnt_s;
      p0_idx_q   <= alu_idx_s;
      p1_valid_q <= div_gnt_s;
      p1_idx_q   <= div_idx_s;
      if (alu_gnt_s) begin
        wk0_pdst_q <= io_slot_pdst[alu_idx_s*PDST_W +: PDST_W];
      end
      if (io_kill) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (div_gnt_s) begin
              cnt_q      <= CW'(DIV_LAT - 1);
              div_pdst_q <= io_slot_pdst[div_idx_s*PDST_W +: PDST_W];
              state_q    <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
          BUSY: begin
            if (cnt_q == CW'(1)) begin
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign io_port0_valid              = p0_valid_q;
  assign io_port0_idx                = p0_idx_q;
  assign io_port1_valid              = p1_valid_q;
  assign io_port1_idx                = p1_idx_q;
  assign io_div_busy                 = (state_q == BUSY);
  assign io_wakeup_ports_0_valid     = p0_valid_q;
  assign io_wakeup_ports_0_bits_pdst = wk0_pdst_q;
  assign io_wakeup_ports_1_valid     = (state_q == DONE);
  assign io_wakeup_ports_1_bits_pdst = div_pdst_q;

endmodule

// File: tb/tb_issue_select.sv
// Directed self-checking bench for issue_select (DIV_LAT=4).
module tb_issue_select;

  localparam int N  = 8;
  localparam int PW = 7;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_kill;
  logic [N-1:0]  io_slot_request, io_slot_is_div, io_slot_grant;
  logic [N*PW-1:0] io_slot_pdst;
  logic          io_port0_valid, io_port1_valid, io_div_busy;
  logic [2:0]    io_port0_idx, io_port1_idx;
  logic          wk0_v, wk1_v;
  logic [PW-1:0] wk0_p, wk1_p;

  int checks = 0;
  int errors = 0;

  issue_select #(.NUM_SLOTS(N), .DIV_LAT(DL), .PDST_W(PW)) dut (
    .clk(clk), .reset(reset), .io_kill(io_kill),
    .io_slot_request(io_slot_request), .io_slot_is_div(io_slot_is_div),
    .io_slot_pdst(io_slot_pdst), .io_slot_grant(io_slot_grant),
    .io_port0_valid(io_port0_valid), .io_port0_idx(io_port0_idx),
    .io_port1_valid(io_port1_valid), .io_port1_idx(io_port1_idx),
    .io_div_busy(io_div_busy),
    .io_wakeup_ports_0_valid(wk0_v), .io_wakeup_ports_0_bits_pdst(wk0_p),
    .io_wakeup_ports_1_valid(wk1_v), .io_wakeup_ports_1_bits_pdst(wk1_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven/sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pdst(input int slot, input logic [PW-1:0] v);
    io_slot_pdst[slot*PW +: PW] = v;
  endtask

  initial begin
    reset = 1'b1; io_kill = 1'b0;
    io_slot_request = '0; io_slot_is_div = '0; io_slot_pdst = '0;
    step(); step();
    chk("rst_p0v", {31'd0, io_port0_valid}, 32'd0);
    chk("rst_p1v", {31'd0, io_port1_valid}, 32'd0);
    chk("rst_busy", {31'd0, io_div_busy}, 32'd0);
    chk("rst_wk1", {31'd0, wk1_v}, 32'd0);
    chk("rst_wk1p", {25'd0, wk1_p}, 32'd0);
    reset = 1'b0;
    step();

    // Age-ordered ALU pick
    io_slot_request = 8'b0110_0100; set_pdst(2, 7'h15); set_pdst(5, 7'h25);
    #1 chk("alu_grant", {24'd0, io_slot_grant}, 32'h04);
    step();
    io_slot_request = '0;
    chk("alu_p0v", {31'd0, io_port0_valid}, 32'd1);
    chk("alu_p0idx", {29'd0, io_port0_idx}, 32'd2);
    chk("alu_wk0v", {31'd0, wk0_v}, 32'd1);
    chk("alu_wk0p", {25'd0, wk0_p}, 32'h15);
    chk("alu_p1v", {31'd0, io_port1_valid}, 32'd0);
    step();
    chk("alu_idle_p0v", {31'd0, io_port0_valid}, 32'd0);

    // Single divide on slot 5: busy for DL-1 cycles, one wakeup at t+DL
    io_slot_request = 8'b0010_0000; io_slot_is_div = 8'b0010_0000; set_pdst(5, 7'h33);
    #1 chk("div_grant", {24'd0, io_slot_grant}, 32'h20);
    step();
    io_slot_request = '0;
    chk("div_p1v", {31'd0, io_port1_valid}, 32'd1);
    chk("div_p1idx", {29'd0, io_port1_idx}, 32'd5);
    chk("div_busy1", {31'd0, io_div_busy}, 32'd1);
    chk("div_wk1_early", {31'd0, wk1_v}, 32'd0);
    // A div request during BUSY must not be granted
    io_slot_request = 8'b0000_1000; io_slot_is_div = 8'b0000_1000;
    #1 chk("div_blocked", {24'd0, io_slot_grant}, 32'h00);
    io_slot_request = '0;
    step();
    chk("div_busy2", {31'd0, io_div_busy}, 32'd1);
    chk("div_wk1_2", {31'd0, wk1_v}, 32'd0);
    step();
    chk("div_busy3", {31'd0, io_div_busy}, 32'd1);
    chk("div_wk1_3", {31'd0, wk1_v}, 32'd0);
    step();
    chk("div_done_busy", {31'd0, io_div_busy}, 32'd0);
    chk("div_wk1v", {31'd0, wk1_v}, 32'd1);
    chk("div_wk1p", {25'd0, wk1_p}, 32'h33);
    step();
    chk("div_wk1_once", {31'd0, wk1_v}, 32'd0);
    chk("div_idle_busy", {31'd0, io_div_busy}, 32'd0);

    // Back-to-back divides: slot 1 at t, slot 3 in the DONE cycle t+DL
    set_pdst(1, 7'h11); set_pdst(3, 7'h13);
    io_slot_request = 8'b0000_1010; io_slot_is_div = 8'b0000_1010;
    #1 chk("b2b_g0", {24'd0, io_slot_grant}, 32'h02);
    step();
    io_slot_request = 8'b0000_1000;
    for (int k = 1; k < DL; k++) begin
      #1 chk($sformatf("b2b_gap%0d", k), {24'd0, io_slot_grant}, 32'h00);
      step();
    end
    #1 chk("b2b_g1", {24'd0, io_slot_grant}, 32'h08);
    chk("b2b_wk1v_a", {31'd0, wk1_v}, 32'd1);
    chk("b2b_wk1p_a", {25'd0, wk1_p}, 32'h11);
    step();
    io_slot_request = '0;
    chk("b2b_p1idx", {29'd0, io_port1_idx}, 32'd3);
    step(); step(); step();
    chk("b2b_wk1v_b", {31'd0, wk1_v}, 32'd1);
    chk("b2b_wk1p_b", {25'd0, wk1_p}, 32'h13);
    step();

    // Kill during a divide with an ALU request pending
    io_slot_request = 8'b0010_0000; io_slot_is_div = 8'b0010_0000;
    step();
    io_slot_request = '0;
    step();
    io_slot_request = 8'b0000_0001; io_slot_is_div = 8'b0000_0000; io_kill = 1'b1;
    #1 chk("kill_grant", {24'd0, io_slot_grant}, 32'h00);
    step();
    io_kill = 1'b0; io_slot_request = '0;
    chk("kill_p0v", {31'd0, io_port0_valid}, 32'd0);
    chk("kill_p1v", {31'd0, io_port1_valid}, 32'd0);
    chk("kill_wk0v", {31'd0, wk0_v}, 32'd0);
    chk("kill_busy", {31'd0, io_div_busy}, 32'd0);
    for (int k = 0; k < DL + 2; k++) begin
      chk($sformatf("kill_nowk1_%0d", k), {31'd0, wk1_v}, 32'd0);
      step();
    end

    // Mixed: slot 0 div on port 1, slot 1 ALU on port 0, same cycle
    set_pdst(0, 7'h40); set_pdst(1, 7'h41);
    io_slot_request = 8'b0000_0011; io_slot_is_div = 8'b0000_0001;
    #1 chk("mix_grant", {24'd0, io_slot_grant}, 32'h03);
    step();
    io_slot_request = '0; io_slot_is_div = '0;
    chk("mix_p0v", {31'd0, io_port0_valid}, 32'd1);
    chk("mix_p0idx", {29'd0, io_port0_idx}, 32'd1);
    chk("mix_wk0p", {25'd0, wk0_p}, 32'h41);
    chk("mix_p1v", {31'd0, io_port1_valid}, 32'd1);
    chk("mix_p1idx", {29'd0, io_port1_idx}, 32'd0);
    step(); step(); step();
    chk("mix_wk1p", {25'd0, wk1_p}, 32'h40);
    step();

    // All slots requesting ALU every cycle, starting from a fresh reset
    reset = 1'b1; step(); reset = 1'b0;
    io_slot_request = 8'hFF; io_slot_is_div = 8'h00;
    for (int k = 0; k <= N; k++) begin
      int exp_idx;
`ifdef ISSUE_SELECT_RR_EN
      exp_idx = k % N;
`else
      exp_idx = 0;
`endif
      #1 chk($sformatf("all_grant%0d", k), {24'd0, io_slot_grant}, 32'd1 << exp_idx);
      step();
      chk($sformatf("all_p0idx%0d", k), {29'd0, io_port0_idx}, exp_idx);
    end
    io_slot_request = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
